// File: rtl/synth_pkg.sv
// Shared types and constants for the note sequencer: FSM encoding, note width,
// note codes and the pattern contents.
package synth_pkg;

  localparam int NOTE_W = 4;

  typedef enum logic [1:0] {
    PAUSED,
    SOUND,
    GAP
  } state_t;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd10;
  localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd12;
  localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd15;

  // Full 16-step pattern; shorter NUM_STEPS settings play a prefix of it.
  function automatic logic [NOTE_W-1:0] pattern_note(input logic [3:0] idx);
    logic [NOTE_W-1:0] n;
    case (idx)
      4'd0:    n = NOTE_C4;
      4'd1:    n = NOTE_D4;
      4'd2:    n = NOTE_REST;
      4'd3:    n = NOTE_E4;
      4'd4:    n = NOTE_F4;
      4'd5:    n = NOTE_REST;
      4'd6:    n = NOTE_G4;
      4'd7:    n = NOTE_A4;
      4'd8:    n = NOTE_B4;
      4'd9:    n = NOTE_REST;
      4'd10:   n = NOTE_D4;
      4'd11:   n = NOTE_E4;
      4'd12:   n = NOTE_C4;
      4'd13:   n = NOTE_REST;
      4'd14:   n = NOTE_C5;
      default: n = NOTE_REST;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_pattern_rom.sv
// Combinational step -> note lookup; steps beyond the pattern length read as rest.
module seq_pattern_rom
  import synth_pkg::*;
#(
  parameter int NUM_STEPS = 16
) (
  input  logic [3:0]        idx,
  output logic [NOTE_W-1:0] note
);

  localparam logic [4:0] NUM_STEPS_W = 5'(NUM_STEPS);

  always_comb begin
    note = NOTE_REST;
    if ({1'b0, idx} < NUM_STEPS_W) note = pattern_note(idx);
  end

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: walks a fixed note pattern at TICKS_PER_STEP cycles per step,
// gating each note off for the last GAP_TICKS cycles of its step.
module note_sequencer
  import synth_pkg::*;
#(
  parameter int TICKS_PER_STEP = 12500000,
  parameter int GAP_TICKS      = 1250000,
  parameter int NUM_STEPS      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              rewind,
  output logic [NOTE_W-1:0] note,
  output logic              gate,
  output logic [3:0]        step,
  output logic              step_pulse
);

  localparam int TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
  localparam logic [TICK_W-1:0] SOUND_END = TICK_W'(TICKS_PER_STEP - GAP_TICKS);
  localparam logic [3:0]        STEP_LAST = 4'(NUM_STEPS - 1);

  state_t            state, next_state;
  logic [TICK_W-1:0] tick_cnt, tick_next;
  logic [3:0]        step_next;
  logic              pulse_next;
  logic              gate_next;
  logic [NOTE_W-1:0] next_note;

  seq_pattern_rom #(.NUM_STEPS(NUM_STEPS)) u_note_rom (
    .idx  (step),
    .note (note)
  );

  seq_pattern_rom #(.NUM_STEPS(NUM_STEPS)) u_next_rom (
    .idx  (step_next),
    .note (next_note)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PAUSED;
      tick_cnt   <= '0;
      step       <= '0;
      step_pulse <= 1'b0;
      gate       <= 1'b0;
    end else begin
      state      <= next_state;
      tick_cnt   <= tick_next;
      step       <= step_next;
      step_pulse <= pulse_next;
      gate       <= gate_next;
    end
  end

  // Phase decision looks at the pre-edge tick; rewind outranks play and wrap.
  always_comb begin
    next_state = state;
    tick_next  = tick_cnt;
    step_next  = step;
    pulse_next = 1'b0;
    if (rewind) begin
      next_state = PAUSED;
      tick_next  = '0;
      step_next  = '0;
    end else if (!play) begin
      next_state = PAUSED;
    end else begin
      next_state = (tick_cnt < SOUND_END) ? SOUND : GAP;
      if (tick_cnt == TICK_LAST) begin
        tick_next  = '0;
        pulse_next = 1'b1;
        step_next  = (step == STEP_LAST) ? '0 : step + 4'd1;
      end else begin
        tick_next = tick_cnt + TICK_W'(1);
      end
    end
  end

  always_comb begin
    gate_next = (next_state == SOUND) && (next_note != NOTE_REST);
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with 8 ticks/step, 2 gap ticks, 4 steps,
// pattern {1,3,0,5}.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic       rewind;
  logic [3:0] note;
  logic       gate;
  logic [3:0] step;
  logic       step_pulse;

  note_sequencer #(
    .TICKS_PER_STEP (8),
    .GAP_TICKS      (2),
    .NUM_STEPS      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .rewind     (rewind),
    .note       (note),
    .gate       (gate),
    .step       (step),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       gate;
    logic [3:0] step;
    logic [3:0] note;
    logic       pulse;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference position: ticks into the step, step index, registered outputs.
  int   m_pos, m_step;
  logic m_gate, m_pulse;
  int   g_cnt, p_cnt, g_step2;

  function automatic int pat(input int i);
    case (i)
      0: return 1;
      1: return 3;
      2: return 0;
      3: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0; m_step = 0; m_gate = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_edge(input logic p, input logic r);
    if (r) begin
      model_reset();
    end else if (!p) begin
      m_gate = 1'b0; m_pulse = 1'b0;
    end else begin
      m_gate  = (m_pos < 6) && (pat(m_step) != 0);
      m_pulse = (m_pos == 7);
      if (m_pos == 7) begin
        m_pos  = 0;
        m_step = (m_step + 1) % 4;
      end else begin
        m_pos = m_pos + 1;
      end
    end
  endtask

  task automatic cyc(input logic p, input logic r);
    exp_t e;
    play = p; rewind = r;
    model_edge(p, r);
    @(posedge clk);
    e.gate  = m_gate;
    e.step  = 4'(m_step);
    e.note  = 4'(pat(m_step));
    e.pulse = m_pulse;
    exp_q.push_back(e);
    @(negedge clk);
    g_cnt = g_cnt + int'(gate);
    p_cnt = p_cnt + int'(step_pulse);
    if (step == 4'd2 && gate) g_step2 = g_step2 + 1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic clr();
    g_cnt = 0; p_cnt = 0; g_step2 = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (gate !== e.gate || step !== e.step || note !== e.note || step_pulse !== e.pulse) begin
        failures = failures + 1;
        $display("FAIL cycle t=%0t: got gate=%0b step=%0d note=%0d pulse=%0b expected gate=%0b step=%0d note=%0d pulse=%0b",
                 $time, gate, step, note, step_pulse, e.gate, e.step, e.note, e.pulse);
      end
    end
  end

  initial begin
    reset = 1'b0; play = 1'b0; rewind = 1'b0;
    model_reset();
    clr();
    @(negedge clk);
    chk("reset_gate", int'(gate), 0);
    chk("reset_step", int'(step), 0);
    chk("reset_pulse", int'(step_pulse), 0);
    chk("reset_note", int'(note), 1);
    reset = 1'b1;

    // Steady play over one full pattern
    clr();
    repeat (32) cyc(1'b1, 1'b0);
    chk("steady_gate_cycles", g_cnt, 18);
    chk("steady_pulses", p_cnt, 4);
    chk("steady_rest_gate", g_step2, 0);
    chk("steady_step_wrapped", int'(step), 0);

    // Pause at tick 3 of step 1, then resume
    repeat (11) cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0);
    chk("pause_step", int'(step), 1);
    chk("pause_gate", int'(gate), 0);
    clr();
    repeat (5) cyc(1'b1, 1'b0);
    chk("resume_gate_cycles", g_cnt, 3);
    chk("resume_step", int'(step), 2);
    chk("resume_pulse", int'(step_pulse), 1);

    // Rewind on the step 3 -> 0 wrap edge
    repeat (15) cyc(1'b1, 1'b0);
    chk("pre_rewind_step", int'(step), 3);
    cyc(1'b1, 1'b1);
    chk("rewind_step", int'(step), 0);
    chk("rewind_pulse", int'(step_pulse), 0);
    chk("rewind_gate", int'(gate), 0);
    clr();
    repeat (6) cyc(1'b1, 1'b0);
    chk("post_rewind_sound", g_cnt, 6);
    repeat (2) cyc(1'b1, 1'b0);
    chk("post_rewind_gap", g_cnt, 6);
    chk("post_rewind_step", int'(step), 1);

    // Asynchronous reset in the middle of step 2
    repeat (11) cyc(1'b1, 1'b0);
    chk("pre_reset_step", int'(step), 2);
    #1 reset = 1'b0;
    #1;
    chk("async_step", int'(step), 0);
    chk("async_gate", int'(gate), 0);
    chk("async_pulse", int'(step_pulse), 0);
    chk("async_note", int'(note), 1);
    model_reset();
    #1 reset = 1'b1;

    // Play toggling every cycle
    clr();
    repeat (7) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
    chk("toggle_step_hold", int'(step), 0);
    cyc(1'b1, 1'b0);
    chk("toggle_advance", int'(step), 1);
    chk("toggle_pulse", int'(step_pulse), 1);
    cyc(1'b0, 1'b0);
    chk("toggle_gate_cycles", g_cnt, 6);
    chk("toggle_pulses", p_cnt, 1);

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
